// File: rtl/alu_mem_stage.sv
// Execute/memory slice of the single-cycle MIPS core: ALU control decode, 32-bit ALU,
// zero flag, jr detection and a word-addressed data memory indexed by the ALU result.
module alu_mem_stage #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  aluop,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [31:0] store_data,
    input  logic        memread,
    input  logic        memwrite,
    output logic [3:0]  alu_ctrl,
    output logic        jump_reg,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] read_data
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;
    localparam logic [3:0] CTRL_SLL = 4'b1000;
    localparam logic [3:0] CTRL_SRL = 4'b1001;
    localparam logic [3:0] CTRL_BAD = 4'b1111;

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] index;

    always_comb begin
        alu_ctrl = CTRL_BAD;
        case (aluop)
            2'b00: alu_ctrl = CTRL_ADD;
            2'b01: alu_ctrl = CTRL_SUB;
            2'b11: alu_ctrl = CTRL_OR;
            default: begin
                case (funct)
                    6'b100000: alu_ctrl = CTRL_ADD;
                    6'b100010: alu_ctrl = CTRL_SUB;
                    6'b100100: alu_ctrl = CTRL_AND;
                    6'b100101: alu_ctrl = CTRL_OR;
                    6'b100111: alu_ctrl = CTRL_NOR;
                    6'b101010: alu_ctrl = CTRL_SLT;
                    6'b000000: alu_ctrl = CTRL_SLL;
                    6'b000010: alu_ctrl = CTRL_SRL;
                    6'b001000: alu_ctrl = CTRL_ADD;  // jr still drives rs through the adder
                    default:   alu_ctrl = CTRL_BAD;
                endcase
            end
        endcase
    end

    assign jump_reg = (aluop == 2'b10) && (funct == 6'b001000);

    always_comb begin
        alu_result = 32'd0;
        case (alu_ctrl)
            CTRL_AND: alu_result = operand_a & operand_b;
            CTRL_OR:  alu_result = operand_a | operand_b;
            CTRL_ADD: alu_result = operand_a + operand_b;
            CTRL_SUB: alu_result = operand_a - operand_b;
            CTRL_SLT: alu_result = ($signed(operand_a) < $signed(operand_b)) ? 32'd1 : 32'd0;
            CTRL_NOR: alu_result = ~(operand_a | operand_b);
            CTRL_SLL: alu_result = operand_b << shamt;
            CTRL_SRL: alu_result = operand_b >> shamt;
            default:  alu_result = 32'd0;
        endcase
    end

    assign zero = (alu_result == 32'd0);

    // Byte offset and bits above the memory depth are dropped, so addresses wrap.
    assign index = alu_result[AW+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (memwrite) begin
            mem[index] <= store_data;
        end
    end

    assign read_data = (memread && reset) ? mem[index] : 32'd0;

endmodule

// File: tb/tb_alu_mem_stage.sv
// Directed bench for alu_mem_stage: decode, ALU arithmetic/logic/shift, jr, stores,
// read-during-write and asynchronous memory clear.
module tb_alu_mem_stage;

    logic        clk;
    logic        reset;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] store_data;
    logic        memread;
    logic        memwrite;
    logic [3:0]  alu_ctrl;
    logic        jump_reg;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] read_data;

    int checks = 0;
    int errors = 0;

    alu_mem_stage #(.MEM_WORDS(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .aluop      (aluop),
        .funct      (funct),
        .shamt      (shamt),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .store_data (store_data),
        .memread    (memread),
        .memwrite   (memwrite),
        .alu_ctrl   (alu_ctrl),
        .jump_reg   (jump_reg),
        .alu_result (alu_result),
        .zero       (zero),
        .read_data  (read_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
        aluop = op;
        funct = fn;
        shamt = sh;
        operand_a = a;
        operand_b = b;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        memread = 1'b0;
        memwrite = 1'b0;
        store_data = 32'd0;
        drive(2'b00, 6'd0, 5'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        memread = 1'b1;
        drive(2'b00, 6'd0, 5'd0, 32'h10, 32'h0);
        checks++;
        if (alu_result !== 32'h10) begin
            errors++;
            $display("FAIL reset_addr got %h exp %h", alu_result, 32'h10);
        end
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_read got %h exp %h", read_data, 32'h0);
        end
    endtask

    task automatic test_add_sub();
        drive(2'b10, 6'b100000, 5'd0, 32'h7FFFFFFF, 32'h1);
        checks++;
        if (alu_ctrl !== 4'b0010) begin
            errors++;
            $display("FAIL add_ctrl got %b exp %b", alu_ctrl, 4'b0010);
        end
        checks++;
        if (alu_result !== 32'h80000000 || zero !== 1'b0) begin
            errors++;
            $display("FAIL add_result got %h/%b exp 80000000/0", alu_result, zero);
        end
        drive(2'b10, 6'b100010, 5'd0, 32'd5, 32'd5);
        checks++;
        if (alu_ctrl !== 4'b0110 || alu_result !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero got %b/%h/%b exp 0110/0/1", alu_ctrl, alu_result, zero);
        end
        drive(2'b01, 6'b111111, 5'd0, 32'd0, 32'd1);
        checks++;
        if (alu_result !== 32'hFFFFFFFF || zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_wrap got %h/%b exp ffffffff/0", alu_result, zero);
        end
        drive(2'b11, 6'd0, 5'd0, 32'hF0F0_0000, 32'h0000_0F0F);
        checks++;
        if (alu_ctrl !== 4'b0001 || alu_result !== 32'hF0F00F0F) begin
            errors++;
            $display("FAIL ori got %b/%h exp 0001/f0f00f0f", alu_ctrl, alu_result);
        end
    endtask

    task automatic test_logic_shift();
        drive(2'b10, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'h1);
        checks++;
        if (alu_ctrl !== 4'b0111 || alu_result !== 32'h1) begin
            errors++;
            $display("FAIL slt_neg got %b/%h exp 0111/1", alu_ctrl, alu_result);
        end
        drive(2'b10, 6'b101010, 5'd0, 32'h1, 32'hFFFFFFFF);
        checks++;
        if (alu_result !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL slt_pos got %h/%b exp 0/1", alu_result, zero);
        end
        drive(2'b10, 6'b000000, 5'd4, 32'hFFFF, 32'h1);
        checks++;
        if (alu_ctrl !== 4'b1000 || alu_result !== 32'h10) begin
            errors++;
            $display("FAIL sll got %b/%h exp 1000/10", alu_ctrl, alu_result);
        end
        drive(2'b10, 6'b000010, 5'd31, 32'h0, 32'h80000000);
        checks++;
        if (alu_ctrl !== 4'b1001 || alu_result !== 32'h1) begin
            errors++;
            $display("FAIL srl got %b/%h exp 1001/1", alu_ctrl, alu_result);
        end
        drive(2'b10, 6'b100111, 5'd0, 32'h0, 32'h0);
        checks++;
        if (alu_ctrl !== 4'b1100 || alu_result !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL nor got %b/%h exp 1100/ffffffff", alu_ctrl, alu_result);
        end
        drive(2'b10, 6'b100100, 5'd0, 32'hFF00FF00, 32'h0FF00FF0);
        checks++;
        if (alu_ctrl !== 4'b0000 || alu_result !== 32'h0F000F00) begin
            errors++;
            $display("FAIL and got %b/%h exp 0000/0f000f00", alu_ctrl, alu_result);
        end
        drive(2'b10, 6'b100101, 5'd0, 32'h00000003, 32'h00000030);
        checks++;
        if (alu_ctrl !== 4'b0001 || alu_result !== 32'h33) begin
            errors++;
            $display("FAIL or got %b/%h exp 0001/33", alu_ctrl, alu_result);
        end
    endtask

    task automatic test_decode_jr();
        drive(2'b10, 6'b001000, 5'd0, 32'h400, 32'h0);
        checks++;
        if (jump_reg !== 1'b1 || alu_ctrl !== 4'b0010 || alu_result !== 32'h400) begin
            errors++;
            $display("FAIL jr got %b/%b/%h exp 1/0010/400", jump_reg, alu_ctrl, alu_result);
        end
        drive(2'b00, 6'b001000, 5'd0, 32'h400, 32'h0);
        checks++;
        if (jump_reg !== 1'b0 || alu_ctrl !== 4'b0010) begin
            errors++;
            $display("FAIL jr_aluop00 got %b/%b exp 0/0010", jump_reg, alu_ctrl);
        end
        drive(2'b10, 6'b111111, 5'd0, 32'h12345678, 32'h1);
        checks++;
        if (alu_ctrl !== 4'b1111 || alu_result !== 32'h0 || zero !== 1'b1 || jump_reg !== 1'b0) begin
            errors++;
            $display("FAIL bad_funct got %b/%h/%b exp 1111/0/1", alu_ctrl, alu_result, zero);
        end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        memread = 1'b0;
        memwrite = 1'b1;
        store_data = 32'hDEADBEEF;
        drive(2'b00, 6'd0, 5'd0, 32'h100, 32'h4);
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        memread = 1'b1;
        #1;
        checks++;
        if (read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_load got %h exp deadbeef", read_data);
        end
        drive(2'b00, 6'd0, 5'd0, 32'h107, 32'h0);
        checks++;
        if (read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL byte_offset got %h exp deadbeef", read_data);
        end
        // 0x504 >> 2 = 0x141, low 8 bits 0x41 = index of 0x104
        drive(2'b00, 6'd0, 5'd0, 32'h504, 32'h0);
        checks++;
        if (read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL addr_wrap got %h exp deadbeef", read_data);
        end
        memread = 1'b0;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL read_disabled got %h exp 0", read_data);
        end
    endtask

    task automatic test_rw_collision_reset();
        @(negedge clk);
        memwrite = 1'b1;
        memread = 1'b0;
        store_data = 32'h1;
        drive(2'b00, 6'd0, 5'd0, 32'h20, 32'h0);
        @(negedge clk);
        memread = 1'b1;
        store_data = 32'hCAFEF00D;
        #1;
        checks++;
        if (read_data !== 32'h1) begin
            errors++;
            $display("FAIL rw_before got %h exp 1", read_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (read_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rw_after got %h exp cafef00d", read_data);
        end
        // reset asserted mid-cycle with a write pending: clears and blocks it
        @(negedge clk);
        store_data = 32'h55555555;
        reset = 1'b0;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_read_zero got %h exp 0", read_data);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        memwrite = 1'b0;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_cleared got %h exp 0", read_data);
        end
        drive(2'b00, 6'd0, 5'd0, 32'h100, 32'h0);
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_cleared_other got %h exp 0", read_data);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic_shift();
        test_decode_jr();
        test_store_load();
        test_rw_collision_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
